// File: rtl/hazard_sb.sv
// Purpose: pipeline hazard control: forwarding, load-use stall, branch flush,
//          and a register scoreboard for variable-latency (long) execute ops.
// Latency: control outputs are combinational; scoreboard bit visible to Decode the cycle after accept.
// Backpressure: a full long unit stalls F/D/E and bubbles M; completion in the same cycle frees a slot.
//
// Ports: clk/reset (async, active-high); Decode regs Rs1D/Rs2D/RdD/RegWriteD;
//        Execute regs Rs1E/Rs2E/RdE, ResultSrcE_zero (load), PCSrcE (taken);
//        RdM/RdW + RegWriteM/RegWriteW for forwarding; LongIssueE/LongRdE and
//        LongDoneW/LongRdW from the long unit. Outputs StallF/D/E, FlushD/E,
//        BubbleM, ForwardAE/BE (00 regfile, 01 W, 10 M), LongBusy.
// Optional: define HAZARD_PERF_EN to add 32-bit counters PerfLwStall,
//           PerfSbStall, PerfStructStall, PerfFlush.

module hazard_sb #(
    parameter int REG_AW     = 5,
    parameter int LONG_DEPTH = 2,
    parameter int CNT_W      = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] Rs1D,
    input  logic [REG_AW-1:0] Rs2D,
    input  logic [REG_AW-1:0] RdD,
    input  logic              RegWriteD,
    input  logic [REG_AW-1:0] Rs1E,
    input  logic [REG_AW-1:0] Rs2E,
    input  logic [REG_AW-1:0] RdE,
    input  logic              ResultSrcE_zero,
    input  logic              PCSrcE,
    input  logic [REG_AW-1:0] RdM,
    input  logic [REG_AW-1:0] RdW,
    input  logic              RegWriteM,
    input  logic              RegWriteW,
    input  logic              LongIssueE,
    input  logic [REG_AW-1:0] LongRdE,
    input  logic              LongDoneW,
    input  logic [REG_AW-1:0] LongRdW,
    output logic              StallF,
    output logic              StallD,
    output logic              StallE,
    output logic              FlushD,
    output logic              FlushE,
    output logic              BubbleM,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              LongBusy
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]       PerfLwStall,
    output logic [31:0]       PerfSbStall,
    output logic [31:0]       PerfStructStall,
    output logic [31:0]       PerfFlush
`endif
);

    localparam int              NREG    = 1 << REG_AW;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(LONG_DEPTH);

    logic [NREG-1:0]  sb;
    logic [NREG-1:0]  sb_nxt;
    logic [NREG-1:0]  done_vec;
    logic [NREG-1:0]  set_vec;
    logic [NREG-1:0]  pend_vec;
    logic [CNT_W-1:0] outstanding;
    logic             lw_stall;
    logic             sb_stall;
    logic             struct_stall;
    logic             accept;
    logic             full;

    // M result is younger than W, so it wins when both match.
    function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs);
        if (rs != '0 && RegWriteM && rs == RdM)
            fwd_sel = 2'b10;
        else if (rs != '0 && RegWriteW && rs == RdW)
            fwd_sel = 2'b01;
        else
            fwd_sel = 2'b00;
    endfunction

    assign ForwardAE = fwd_sel(Rs1E);
    assign ForwardBE = fwd_sel(Rs2E);

    assign lw_stall = ResultSrcE_zero && (RdE != '0) && (Rs1D == RdE || Rs2D == RdE);

    always_comb begin
        done_vec = '0;
        if (LongDoneW)
            done_vec[LongRdW] = 1'b1;
    end

    always_comb begin
        set_vec = '0;
        if (accept && LongRdE != '0)
            set_vec[LongRdE] = 1'b1;
    end

    // A completing op writes the regfile in the first half-cycle, so Decode
    // may read it in the same cycle: mask the completing register.
    assign pend_vec = sb & ~done_vec;
    assign sb_stall = pend_vec[Rs1D] | pend_vec[Rs2D] | (RegWriteD & pend_vec[RdD]);

    assign full         = (outstanding == DEPTH_C);
    assign struct_stall = LongIssueE & full & ~LongDoneW;
    assign accept       = LongIssueE & ~struct_stall;

    // Set after clear: a re-issue to the completing register leaves it pending.
    always_comb begin
        sb_nxt    = (sb & ~done_vec) | set_vec;
        sb_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            sb <= '0;
        else
            sb <= sb_nxt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            outstanding <= '0;
        else if (accept && !LongDoneW) begin
            if (!full)
                outstanding <= outstanding + CNT_W'(1);
        end else if (!accept && LongDoneW && outstanding != '0)
            outstanding <= outstanding - CNT_W'(1);
    end

    assign StallF   = lw_stall | sb_stall | struct_stall;
    assign StallD   = lw_stall | sb_stall | struct_stall;
    assign StallE   = struct_stall;
    assign BubbleM  = struct_stall;
    assign FlushD   = PCSrcE;
    // The op held in Execute by a structural stall must survive a D-side stall.
    assign FlushE   = PCSrcE | ((lw_stall | sb_stall) & ~struct_stall);
    assign LongBusy = full;

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            PerfLwStall     <= '0;
            PerfSbStall     <= '0;
            PerfStructStall <= '0;
            PerfFlush       <= '0;
        end else begin
            if (lw_stall)     PerfLwStall     <= PerfLwStall + 32'd1;
            if (sb_stall)     PerfSbStall     <= PerfSbStall + 32'd1;
            if (struct_stall) PerfStructStall <= PerfStructStall + 32'd1;
            if (PCSrcE)       PerfFlush       <= PerfFlush + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_sb.sv
// Purpose: directed bench for hazard_sb with an expected-response queue and a
//          decoupled negedge monitor comparing the full control-output bundle.
// Output bundle order: {StallF,StallD,StallE,FlushD,FlushE,BubbleM,ForwardAE,ForwardBE,LongBusy}.

module tb_hazard_sb;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] Rs1D, Rs2D, RdD, Rs1E, Rs2E, RdE, RdM, RdW, LongRdE, LongRdW;
    logic       RegWriteD, ResultSrcE_zero, PCSrcE, RegWriteM, RegWriteW;
    logic       LongIssueE, LongDoneW;
    logic       StallF, StallD, StallE, FlushD, FlushE, BubbleM, LongBusy;
    logic [1:0] ForwardAE, ForwardBE;
`ifdef HAZARD_PERF_EN
    logic [31:0] PerfLwStall, PerfSbStall, PerfStructStall, PerfFlush;
`endif

    int checks = 0;
    int errors = 0;

    logic [10:0] exp_q[$];
    string       name_q[$];

    always #5 clk = ~clk;

    hazard_sb #(.REG_AW(5), .LONG_DEPTH(2), .CNT_W(4)) dut (
        .clk(clk), .reset(reset),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .RegWriteD(RegWriteD),
        .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .ResultSrcE_zero(ResultSrcE_zero), .PCSrcE(PCSrcE),
        .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .LongIssueE(LongIssueE), .LongRdE(LongRdE),
        .LongDoneW(LongDoneW), .LongRdW(LongRdW),
        .StallF(StallF), .StallD(StallD), .StallE(StallE),
        .FlushD(FlushD), .FlushE(FlushE), .BubbleM(BubbleM),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .LongBusy(LongBusy)
`ifdef HAZARD_PERF_EN
        , .PerfLwStall(PerfLwStall), .PerfSbStall(PerfSbStall),
        .PerfStructStall(PerfStructStall), .PerfFlush(PerfFlush)
`endif
    );

    function automatic logic [10:0] mk(input logic sf, input logic sd, input logic se,
                                       input logic fd, input logic fe, input logic bm,
                                       input logic [1:0] fa, input logic [1:0] fb,
                                       input logic lb);
        mk = {sf, sd, se, fd, fe, bm, fa, fb, lb};
    endfunction

    // Monitor: the DUT presents a fresh output bundle every cycle; compare
    // whatever expectation the driver queued for this cycle.
    always @(negedge clk) begin
        logic [10:0] act;
        logic [10:0] e;
        string       n;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            n   = name_q.pop_front();
            act = {StallF, StallD, StallE, FlushD, FlushE, BubbleM, ForwardAE, ForwardBE, LongBusy};
            checks++;
            if (act !== e) begin
                errors++;
                $display("FAIL %s: got %b expected %b", n, act, e);
            end
        end
    end

    task automatic idle();
        Rs1D = 0; Rs2D = 0; RdD = 0; RegWriteD = 0;
        Rs1E = 0; Rs2E = 0; RdE = 0; ResultSrcE_zero = 0; PCSrcE = 0;
        RdM = 0; RdW = 0; RegWriteM = 0; RegWriteW = 0;
        LongIssueE = 0; LongRdE = 0; LongDoneW = 0; LongRdW = 0;
    endtask

    // Inputs are already applied; queue the expectation and move one cycle on.
    task automatic apply(input string n, input logic [10:0] e);
        exp_q.push_back(e);
        name_q.push_back(n);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        reset = 1'b1;
        @(posedge clk); #1;
        apply("reset_state", mk(0,0,0,0,0,0,2'b00,2'b00,0));
        reset = 1'b0;

        // Forwarding priority
        idle(); Rs1E = 5; RdM = 5; RegWriteM = 1; RdW = 5; RegWriteW = 1;
        apply("fwd_a_m", mk(0,0,0,0,0,0,2'b10,2'b00,0));
        RegWriteM = 0;
        apply("fwd_a_w", mk(0,0,0,0,0,0,2'b01,2'b00,0));
        Rs1E = 0;
        apply("fwd_a_x0", mk(0,0,0,0,0,0,2'b00,2'b00,0));
        idle(); Rs1E = 3; Rs2E = 6; RdM = 6; RegWriteM = 1; RdW = 6; RegWriteW = 1;
        apply("fwd_b_m", mk(0,0,0,0,0,0,2'b00,2'b10,0));
        RdM = 7;
        apply("fwd_b_w", mk(0,0,0,0,0,0,2'b00,2'b01,0));

        // Load-use
        idle(); ResultSrcE_zero = 1; RdE = 7; Rs2D = 7;
        apply("loaduse", mk(1,1,0,0,1,0,2'b00,2'b00,0));
        RdE = 0;
        apply("loaduse_x0", mk(0,0,0,0,0,0,2'b00,2'b00,0));

        // Scoreboard RAW on x9
        idle(); LongIssueE = 1; LongRdE = 9;
        apply("issue9", mk(0,0,0,0,0,0,2'b00,2'b00,0));
        idle(); Rs1D = 9;
        apply("raw9_a", mk(1,1,0,0,1,0,2'b00,2'b00,0));
        apply("raw9_b", mk(1,1,0,0,1,0,2'b00,2'b00,0));
        LongDoneW = 1; LongRdW = 9;
        apply("done9_bypass", mk(0,0,0,0,0,0,2'b00,2'b00,0));
        idle(); Rs1D = 9;
        apply("after9", mk(0,0,0,0,0,0,2'b00,2'b00,0));

        // WAW on x10
        idle(); LongIssueE = 1; LongRdE = 10;
        apply("issue10", mk(0,0,0,0,0,0,2'b00,2'b00,0));
        idle(); RdD = 10; RegWriteD = 1;
        apply("waw10", mk(1,1,0,0,1,0,2'b00,2'b00,0));
        RegWriteD = 0;
        apply("waw10_nowrite", mk(0,0,0,0,0,0,2'b00,2'b00,0));
        idle(); LongDoneW = 1; LongRdW = 10;
        apply("done10", mk(0,0,0,0,0,0,2'b00,2'b00,0));

        // Structural hazard at LONG_DEPTH=2
        idle(); LongIssueE = 1; LongRdE = 3;
        apply("issue3", mk(0,0,0,0,0,0,2'b00,2'b00,0));
        LongRdE = 4;
        apply("issue4", mk(0,0,0,0,0,0,2'b00,2'b00,0));
        idle(); LongIssueE = 1; LongRdE = 11; Rs1D = 3;
        apply("struct_full", mk(1,1,1,0,0,1,2'b00,2'b00,1));
        Rs1D = 0; LongDoneW = 1; LongRdW = 3;
        apply("struct_done", mk(0,0,0,0,0,0,2'b00,2'b00,1));
        idle();
        apply("busy_hold", mk(0,0,0,0,0,0,2'b00,2'b00,1));
        idle(); Rs1D = 3;
        apply("x3_free", mk(0,0,0,0,0,0,2'b00,2'b00,1));

        // Drain x4 and x11
        idle(); LongDoneW = 1; LongRdW = 4;
        apply("done4", mk(0,0,0,0,0,0,2'b00,2'b00,1));
        LongRdW = 11;
        apply("done11", mk(0,0,0,0,0,0,2'b00,2'b00,0));

        // Same-cycle set and clear of x6
        idle(); LongIssueE = 1; LongRdE = 6;
        apply("issue6", mk(0,0,0,0,0,0,2'b00,2'b00,0));
        LongDoneW = 1; LongRdW = 6;
        apply("setclr6", mk(0,0,0,0,0,0,2'b00,2'b00,0));
        idle(); Rs2D = 6;
        apply("x6_pending", mk(1,1,0,0,1,0,2'b00,2'b00,0));

        // Branch over a scoreboard stall
        PCSrcE = 1;
        apply("branch_sb", mk(1,1,0,1,1,0,2'b00,2'b00,0));

        // Fill, then asynchronous reset mid-cycle
        idle(); LongIssueE = 1; LongRdE = 7;
        apply("issue7", mk(0,0,0,0,0,0,2'b00,2'b00,0));
        idle(); Rs1D = 6;
        apply("busy2", mk(1,1,0,0,1,0,2'b00,2'b00,1));
        reset = 1'b1;
        apply("async_reset", mk(0,0,0,0,0,0,2'b00,2'b00,0));
        reset = 1'b0;
        apply("post_reset", mk(0,0,0,0,0,0,2'b00,2'b00,0));

        // Spurious done must not underflow the counter
        idle(); LongDoneW = 1; LongRdW = 5;
        apply("spurious_done", mk(0,0,0,0,0,0,2'b00,2'b00,0));
        idle(); LongIssueE = 1; LongRdE = 5;
        apply("issue5", mk(0,0,0,0,0,0,2'b00,2'b00,0));
        apply("issue5_again", mk(0,0,0,0,0,0,2'b00,2'b00,0));
        idle();
        apply("busy_after_two", mk(0,0,0,0,0,0,2'b00,2'b00,1));

        @(negedge clk); #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
